ext_cache_model: RTL and testbench
==================================

Name: ext_cache_model

Overview:
- Behavioural per-core L1 cache/memory model for the dual-core RV32 simulation top.
- One instance per core per cache type (instruction or data).
- Accepts one request per cycle over a packed 72-bit argument bus and returns a one-entry-buffered response over a packed 54-bit result bus.
- Raises `finish` when the program stores to the exit address.

Parameters:
- CORE_ID, 0, core index (0/1); used only for trace and identification.
- CACHE_TY, 0, cache type, 0 = instruction, 1 = data; used only for trace and identification.
- ADDR_BITS, 12, word-index width; backing array holds 2^ADDR_BITS 32-bit words.
- EXIT_ADDR, 32'h4000_1000, store address that signals program completion.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- arg  in  72  packed request/control bus:
  - [71] resp_ready
  - [70] req_valid
  - [69:68] req_kind, reserved and ignored
  - [67:64] byte_en
  - [63:32] addr
  - [31:0] wdata
- out  out  54  packed result bus:
  - [53] resp_valid
  - [52] req_ready
  - [51:48] resp byte_en echo
  - [47:32] resp addr[15:0]
  - [31:0] rdata
- finish  out  1  one-cycle pulse: an exit store was accepted.

Behaviour:
- Reset (RST_N low, asynchronous):
  - resp_valid=0, finish=0, resp byte_en/addr/rdata registers=0.
  - Memory array contents are not reset.
- req_ready (combinational) = !resp_valid || resp_ready.
- Accept condition: req_valid && req_ready. Accepting loads the response register on the next rising edge; resp_valid=1 from that edge.
- Latency: exactly one cycle from acceptance to resp_valid.
- Dequeue: resp_valid && resp_ready at an edge clears resp_valid, unless a new request is accepted on the same edge; then the register is overwritten and resp_valid stays 1.
- Full throughput: with resp_ready held high, one request per cycle.
- Word index = addr[ADDR_BITS+1:2]. addr[1:0] and bits above ADDR_BITS+1 are ignored for array access (aliasing/wrap-around).
- Read (byte_en==0): rdata = array[index].
- Write (byte_en!=0):
  - Each set bit i writes wdata[8i+7:8i] into byte i of array[index].
  - rdata = word value before the write (read-old-data).
- Response echo: byte_en and addr[15:0] of the request are echoed in the response.
- Exit store (byte_en!=0 and addr==EXIT_ADDR, full 32-bit compare):
  - The array is not modified.
  - finish=1 for exactly the cycle after acceptance.
  - A normal response is still produced, with rdata=0.
- A read of EXIT_ADDR is a normal array read of the aliased index.
- Request fields presented while req_ready=0 are ignored. No buffering beyond the single response entry.
- Reset asserted mid-operation drops any pending response. A request presented on the reset-release edge is not accepted.
- req_kind has no effect.

Optional Feature:
- Macro EXT_CACHE_TRACE_EN.
- Defined: on every accepted request, $display one line containing CORE_ID, CACHE_TY ("I"/"D"), addr, byte_en, wdata, and the returned rdata. Also prints "EXIT" when finish pulses. Functional outputs are identical to the undefined case.
- Undefined: no simulation output; block is fully synthesizable apart from the array.

Test Plan:
- Reset: hold RST_N=0 with req_valid=1 → out[53]=0, out[52]=1, finish=0; after release, first accepted request responds one cycle later.
- Write/read: write addr 0x10, byte_en 4'hF, wdata 0xDEADBEEF, resp_ready=1 → response rdata=old value. Next, read 0x10 → rdata=0xDEADBEEF, echo addr 0x0010, byte_en 0.
- Byte enables: after the above, write 0x10 with byte_en 4'b0010, wdata 0x0000_5500 → a subsequent read returns 0xDEAD55EF.
- Backpressure: resp_ready=0, two back-to-back requests → first accepted; req_ready=0 for the second, which stays unaccepted until resp_ready=1, after which it responds one cycle later with correct data.
- Simultaneous dequeue+accept: resp_valid=1, resp_ready=1, new read of 0x14 → resp_valid stays 1 and the payload switches to the 0x14 result the next cycle.
- Exit: store to 0x40001000 with wdata 1 → finish=1 for exactly one cycle; the response has rdata 0; array word at the aliased index is unchanged.

Source files
------------

// File: rtl/ext_cache_model.sv
// ext_cache_model: behavioural per-core L1 cache/memory model for the dual-core RV32 sim top.
// One request per cycle in over a packed argument bus; one-entry-buffered response out.
// A store to EXIT_ADDR leaves memory untouched and pulses finish for one cycle.
// Optional trace output: define EXT_CACHE_TRACE_EN to print one line per accepted request.
module ext_cache_model #(
    parameter int unsigned CORE_ID   = 0,
    parameter int unsigned CACHE_TY  = 0,
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [31:0] EXIT_ADDR = 32'h4000_1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [71:0] arg,
    output logic [53:0] out,
    output logic        finish
);

    localparam int unsigned Words = 1 << ADDR_BITS;

    // Unpacked request/control fields
    logic        resp_ready;
    logic        req_valid;
    logic [1:0]  req_kind;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    assign {resp_ready, req_valid, req_kind, req_be, req_addr, req_wdata} = arg;

    // Backing store; deliberately never reset
    logic [31:0] mem [Words];

    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          old_word;
    logic                 req_ready;
    logic                 accept;
    logic                 is_write;
    logic                 is_exit;
    logic                 mem_we;

    // Response register and control state
    logic        resp_valid_q, resp_valid_d;
    logic [3:0]  resp_be_q,    resp_be_d;
    logic [15:0] resp_addr_q,  resp_addr_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        finish_q,     finish_d;
    // Low until the first edge after reset release, so nothing is taken on the release edge
    logic        armed_q;

    // Low address bits and bits above the index are dropped: accesses alias/wrap
    assign word_idx = req_addr[ADDR_BITS+1:2];
    assign old_word = mem[word_idx];

    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = armed_q && req_valid && req_ready;
    assign is_write  = |req_be;
    assign is_exit   = is_write && (req_addr == EXIT_ADDR);
    assign mem_we    = accept && is_write && !is_exit;

    // Next-state for the response entry: load on accept, else clear on dequeue
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_be_d    = resp_be_q;
        resp_addr_d  = resp_addr_q;
        resp_rdata_d = resp_rdata_q;
        finish_d     = 1'b0;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_be_d    = req_be;
            resp_addr_d  = req_addr[15:0];
            // Writes return the pre-write word; the exit store returns zero
            resp_rdata_d = is_exit ? 32'h0 : old_word;
            finish_d     = is_exit;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Response and finish registers with asynchronous reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            resp_valid_q <= 1'b0;
            resp_be_q    <= 4'h0;
            resp_addr_q  <= 16'h0;
            resp_rdata_q <= 32'h0;
            finish_q     <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_be_q    <= resp_be_d;
            resp_addr_q  <= resp_addr_d;
            resp_rdata_q <= resp_rdata_d;
            finish_q     <= finish_d;
        end
    end

    // Arm request acceptance one edge after reset release
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // Byte-enabled write into the backing array
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign out    = {resp_valid_q, req_ready, resp_be_q, resp_addr_q, resp_rdata_q};
    assign finish = finish_q;

`ifdef EXT_CACHE_TRACE_EN
    // Trace each accepted request and each exit pulse
    always @(posedge CLK) begin
        if (RST_N && accept) begin
            $display("[cache core=%0d %s] addr=%h be=%h wdata=%h rdata=%h",
                     CORE_ID, (CACHE_TY == 0) ? "I" : "D", req_addr, req_be, req_wdata,
                     is_exit ? 32'h0 : old_word);
        end
        if (RST_N && finish_q) begin
            $display("[cache core=%0d %s] EXIT", CORE_ID, (CACHE_TY == 0) ? "I" : "D");
        end
    end
`endif

    // req_kind is reserved; identification parameters only matter for trace
    logic unused_sig;
    assign unused_sig = ^{req_kind, CORE_ID, CACHE_TY};

endmodule

// File: tb/tb_ext_cache_model.sv
// Scoreboard bench for ext_cache_model: the driver pushes expected responses, a monitor
// pops and compares them on each response handshake.
module tb_ext_cache_model;

    logic        CLK;
    logic        RST_N;
    logic        resp_ready;
    logic        req_valid;
    logic [1:0]  req_kind;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [71:0] arg;
    logic [53:0] dut_out;
    logic        finish;

    int total = 0;
    int bad   = 0;
    int fin_cycles = 0;

    typedef struct {
        logic [3:0]  be;
        logic [15:0] addr;
        logic [31:0] rdata;
        bit          chk_rd;
    } exp_t;

    exp_t exp_q[$];

    assign arg = {resp_ready, req_valid, req_kind, req_be, req_addr, req_wdata};

    ext_cache_model #(
        .CORE_ID  (0),
        .CACHE_TY (1),
        .ADDR_BITS(12),
        .EXIT_ADDR(32'h4000_1000)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .arg   (arg),
        .out   (dut_out),
        .finish(finish)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request at a falling edge, wait for acceptance, return at the next falling edge
    task automatic issue(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit chk_rd, input logic [31:0] exp_rd);
        int waits;
        exp_t e;
        waits     = 0;
        req_valid = 1'b1;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        req_kind  = 2'($urandom_range(0, 3));
        #1;
        while (!dut_out[52]) begin
            if (waits >= 50) begin
                total++;
                bad++;
                $display("FAIL issue_timeout: addr %h never accepted", addr);
                req_valid = 1'b0;
                return;
            end
            @(negedge CLK);
            #1;
            waits++;
        end
        e.be     = be;
        e.addr   = addr[15:0];
        e.rdata  = exp_rd;
        e.chk_rd = chk_rd;
        exp_q.push_back(e);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    // Monitor: a response is consumed when valid and ready meet at the coming edge
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (RST_N && dut_out[53] && resp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got addr %h rdata %h expected none",
                             dut_out[47:32], dut_out[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_be", 64'(dut_out[51:48]), 64'(e.be));
                    chk("resp_addr", 64'(dut_out[47:32]), 64'(e.addr));
                    if (e.chk_rd) chk("resp_rdata", 64'(dut_out[31:0]), 64'(e.rdata));
                end
            end
        end
    end

    // Count cycles in which finish is high
    always @(posedge CLK) begin
        #1;
        if (finish) fin_cycles++;
    end

    initial begin
        RST_N      = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_kind   = 2'b00;
        req_be     = 4'hF;
        req_addr   = 32'h10;
        req_wdata  = 32'h1234_5678;

        // Reset held with a request pending
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_resp_valid", 64'(dut_out[53]), 64'(1'b0));
        chk("rst_req_ready", 64'(dut_out[52]), 64'(1'b1));
        chk("rst_payload", 64'(dut_out[51:0]), 64'h0);
        chk("rst_finish", 64'(finish), 64'(1'b0));
        @(negedge CLK);
        req_valid = 1'b0;
        RST_N     = 1'b1;
        repeat (2) @(negedge CLK);

        // Write/read with byte enables
        resp_ready = 1'b1;
        issue(4'hF, 32'h10, 32'h1122_3344, 1'b0, 32'h0);
        #1;
        chk("first_latency", 64'(dut_out[53]), 64'(1'b1));
        @(negedge CLK);
        issue(4'hF, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h1122_3344);
        issue(4'h0, 32'h10, 32'h0,         1'b1, 32'hDEAD_BEEF);
        issue(4'h2, 32'h10, 32'h0000_5500, 1'b1, 32'hDEAD_BEEF);
        issue(4'h0, 32'h10, 32'h0,         1'b1, 32'hDEAD_55EF);

        // Aliasing: upper and low address bits ignored for indexing
        issue(4'hF, 32'h4010, 32'hCAFE_F00D, 1'b1, 32'hDEAD_55EF);
        issue(4'h0, 32'h11,   32'h0,         1'b1, 32'hCAFE_F00D);
        issue(4'hF, 32'h14,   32'h0102_0304, 1'b0, 32'h0);
        issue(4'hF, 32'h1000, 32'h5A5A_5A5A, 1'b0, 32'h0);
        @(negedge CLK);

        // Backpressure: second request held off until resp_ready rises
        resp_ready = 1'b0;
        issue(4'h0, 32'h10, 32'h0, 1'b1, 32'hCAFE_F00D);
        req_valid = 1'b1;
        req_be    = 4'h0;
        req_addr  = 32'h14;
        req_wdata = 32'h0;
        #1;
        chk("bp_not_ready", 64'(dut_out[52]), 64'(1'b0));
        @(negedge CLK);
        #1;
        chk("bp_still_not_ready", 64'(dut_out[52]), 64'(1'b0));
        chk("bp_hold_valid", 64'(dut_out[53]), 64'(1'b1));
        chk("bp_hold_data", 64'(dut_out[31:0]), 64'(32'hCAFE_F00D));
        @(negedge CLK);
        resp_ready = 1'b1;
        issue(4'h0, 32'h14, 32'h0, 1'b1, 32'h0102_0304);
        #1;
        chk("bp_second_valid", 64'(dut_out[53]), 64'(1'b1));
        chk("bp_second_data", 64'(dut_out[31:0]), 64'(32'h0102_0304));
        @(negedge CLK);

        // Dequeue and accept on the same edge
        issue(4'hF, 32'h18, 32'h7777_7777, 1'b0, 32'h0);
        issue(4'h0, 32'h14, 32'h0, 1'b1, 32'h0102_0304);
        #1;
        chk("dq_acc_valid", 64'(dut_out[53]), 64'(1'b1));
        chk("dq_acc_addr", 64'(dut_out[47:32]), 64'(16'h0014));
        @(negedge CLK);

        // Exit store
        issue(4'hF, 32'h4000_1000, 32'h1, 1'b1, 32'h0);
        #1;
        chk("exit_finish_hi", 64'(finish), 64'(1'b1));
        @(negedge CLK);
        #1;
        chk("exit_finish_lo", 64'(finish), 64'(1'b0));
        @(negedge CLK);
        issue(4'h0, 32'h4000_1000, 32'h0, 1'b1, 32'h5A5A_5A5A);
        #1;
        chk("exit_read_no_finish", 64'(finish), 64'(1'b0));
        @(negedge CLK);

        // Reset mid-operation drops the pending response
        resp_ready = 1'b0;
        issue(4'h0, 32'h10, 32'h0, 1'b1, 32'hCAFE_F00D);
        #1;
        chk("mid_pending", 64'(dut_out[53]), 64'(1'b1));
        RST_N = 1'b0;
        #1;
        chk("mid_rst_drop", 64'(dut_out[53]), 64'(1'b0));
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST_N      = 1'b1;
        resp_ready = 1'b1;
        repeat (2) @(negedge CLK);
        issue(4'h0, 32'h10, 32'h0, 1'b1, 32'hCAFE_F00D);

        repeat (3) @(negedge CLK);
        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("finish_pulses", 64'(fin_cycles), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
